lift_scheduler: RTL and testbench

- Downstream consumer of request_handler. Reads the registered up, down and car request queues.
- Runs a SCAN-style lift state machine and drives the one-hot car position.
- Generates the per-direction clear strobes that request_handler uses to retire serviced requests.
- Models travel time between floors and door-open dwell time with cycle counters.

---
 rtl/lift_scheduler_pkg.sv | 20 ++
 rtl/lift_scheduler_floor_mask_cmp.sv | 45 ++++
 rtl/lift_scheduler.sv | 179 +++++++++++++++++
 tb/tb_lift_scheduler.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/lift_scheduler_pkg.sv
// rtl/lift_scheduler_pkg.sv - shared state encoding and default timing for the lift scheduler
package lift_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MOVE_UP = 3'd1,
    ST_MOVE_DN = 3'd2,
    ST_ARRIVE  = 3'd3,
    ST_DOOR    = 3'd4
  } state_e;

  localparam int DEF_N_FLOORS      = 8;
  localparam int DEF_TRAVEL_CYCLES = 4;
  localparam int DEF_DOOR_CYCLES   = 6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lift_scheduler_floor_mask_cmp.sv
// rtl/lift_scheduler_floor_mask_cmp.sv - floor_mask_cmp: above/below/at-position request terms
// Masks are built by sweeping the one-hot position, so no adders or comparators are needed.
module floor_mask_cmp #(
  parameter int N_FLOORS = 8
) (
  input  logic [N_FLOORS-1:0] i_pos,
  input  logic [N_FLOORS-1:0] i_up_req,
  input  logic [N_FLOORS-1:0] i_dn_req,
  input  logic [N_FLOORS-1:0] i_flr_req,
  output logic                o_above,
  output logic                o_below,
  output logic                o_up_at,
  output logic                o_dn_at,
  output logic                o_flr_at
);

  logic [N_FLOORS-1:0] above_mask;
  logic [N_FLOORS-1:0] below_mask;
  logic [N_FLOORS-1:0] req;
  logic                seen_lo;
  logic                seen_hi;

  always_comb begin
    above_mask = '0;
    below_mask = '0;
    seen_lo    = 1'b0;
    seen_hi    = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) begin
      above_mask[i] = seen_lo;
      seen_lo       = seen_lo | i_pos[i];
    end
    for (int i = N_FLOORS-1; i >= 0; i--) begin
      below_mask[i] = seen_hi;
      seen_hi       = seen_hi | i_pos[i];
    end
  end

  assign req      = i_up_req | i_dn_req | i_flr_req;
  assign o_above  = |(req & above_mask);
  assign o_below  = |(req & below_mask);
  assign o_up_at  = |(i_up_req & i_pos);
  assign o_dn_at  = |(i_dn_req & i_pos);
  assign o_flr_at = |(i_flr_req & i_pos);

endmodule

// File: rtl/lift_scheduler.sv
// rtl/lift_scheduler.sv - SCAN lift state machine with travel/door timers and request clear strobes
// Optional: LIFT_DOOR_REOPEN_EN lets a new stop request at the open floor extend the door time.
module lift_scheduler
  import lift_scheduler_pkg::*;
#(
  parameter int N_FLOORS      = DEF_N_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] i_up_req_queue,
  input  logic [N_FLOORS-1:0] i_dn_req_queue,
  input  logic [N_FLOORS-1:0] i_flr_req_queue,
  output logic [N_FLOORS-1:0] o_flr_pos,
  output logic                o_up_clr,
  output logic                o_dn_clr,
  output logic                o_flr_clr,
  output logic                o_dir_up,
  output logic                o_moving,
  output logic                o_door_open
);

  localparam int CW = $clog2(max_int(TRAVEL_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

  state_e              state_q, state_d;
  logic [N_FLOORS-1:0] pos_q, pos_d;
  logic                dir_up_q, dir_up_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                up_clr_q, up_clr_d;
  logic                dn_clr_q, dn_clr_d;
  logic                flr_clr_q, flr_clr_d;

  logic above, below, up_at, dn_at, flr_at;
  logic stop, new_dir_up, go_door;
  logic [CW-1:0] cnt_dec;

`ifdef LIFT_DOOR_REOPEN_EN
  logic door_first_q, door_first_d;
`endif

  floor_mask_cmp #(.N_FLOORS(N_FLOORS)) u_floor_mask_cmp (
    .i_pos     (pos_q),
    .i_up_req  (i_up_req_queue),
    .i_dn_req  (i_dn_req_queue),
    .i_flr_req (i_flr_req_queue),
    .o_above   (above),
    .o_below   (below),
    .o_up_at   (up_at),
    .o_dn_at   (dn_at),
    .o_flr_at  (flr_at)
  );

  // A same-direction hall call stops the car; an opposite one only when nothing lies further ahead.
  assign stop       = flr_at | (dir_up_q ? (up_at | (dn_at & ~above))
                                         : (dn_at | (up_at & ~below)));
  assign new_dir_up = dir_up_q ? (above | up_at) : ~(below | dn_at);
  assign cnt_dec    = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dir_up_d  = dir_up_q;
    cnt_d     = cnt_dec;
    up_clr_d  = 1'b0;
    dn_clr_d  = 1'b0;
    flr_clr_d = 1'b0;
    go_door   = 1'b0;
`ifdef LIFT_DOOR_REOPEN_EN
    door_first_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          go_door = 1'b1;
        end else if (above & (dir_up_q | ~below)) begin
          dir_up_d = 1'b1;
          state_d  = ST_MOVE_UP;
          cnt_d    = TRAVEL_LOAD;
        end else if (below) begin
          dir_up_d = 1'b0;
          state_d  = ST_MOVE_DN;
          cnt_d    = TRAVEL_LOAD;
        end
      end
      ST_MOVE_UP: begin
        if (cnt_q == '0) begin
          pos_d   = pos_q << 1;
          state_d = ST_ARRIVE;
        end
      end
      ST_MOVE_DN: begin
        if (cnt_q == '0) begin
          pos_d   = pos_q >> 1;
          state_d = ST_ARRIVE;
        end
      end
      ST_ARRIVE: begin
        if (stop) begin
          go_door = 1'b1;
        end else if (dir_up_q ? above : below) begin
          state_d = dir_up_q ? ST_MOVE_UP : ST_MOVE_DN;
          cnt_d   = TRAVEL_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DOOR: begin
`ifdef LIFT_DOOR_REOPEN_EN
        // The first door cycle is skipped: the bits just strobed are still visible then.
        if (!door_first_q && stop) begin
          go_door = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
`else
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    if (go_door) begin
      state_d   = ST_DOOR;
      cnt_d     = DOOR_LOAD;
      dir_up_d  = new_dir_up;
      flr_clr_d = flr_at;
      up_clr_d  = new_dir_up & up_at;
      dn_clr_d  = ~new_dir_up & dn_at;
`ifdef LIFT_DOOR_REOPEN_EN
      door_first_d = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pos_q     <= {{(N_FLOORS-1){1'b0}}, 1'b1};
      dir_up_q  <= 1'b1;
      cnt_q     <= '0;
      up_clr_q  <= 1'b0;
      dn_clr_q  <= 1'b0;
      flr_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      dir_up_q  <= dir_up_d;
      cnt_q     <= cnt_d;
      up_clr_q  <= up_clr_d;
      dn_clr_q  <= dn_clr_d;
      flr_clr_q <= flr_clr_d;
    end
  end

`ifdef LIFT_DOOR_REOPEN_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      door_first_q <= 1'b0;
    end else begin
      door_first_q <= door_first_d;
    end
  end
`endif

  assign o_flr_pos   = pos_q;
  assign o_up_clr    = up_clr_q;
  assign o_dn_clr    = dn_clr_q;
  assign o_flr_clr   = flr_clr_q;
  assign o_dir_up    = dir_up_q;
  assign o_moving    = (state_q == ST_MOVE_UP) || (state_q == ST_MOVE_DN);
  assign o_door_open = (state_q == ST_DOOR);

endmodule

// File: tb/tb_lift_scheduler.sv
// tb/tb_lift_scheduler.sv - scoreboard bench for lift_scheduler (N=4, travel 2, door 3)
module tb_lift_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] up_q = '0, dn_q = '0, flr_q = '0;
  logic [3:0] pend_up = '0, pend_dn = '0, pend_flr = '0;
  logic [3:0] o_flr_pos;
  logic       o_up_clr, o_dn_clr, o_flr_clr, o_dir_up, o_moving, o_door_open;

  typedef struct packed {
    logic [3:0] pos;
    logic [2:0] bits;
    logic       dir;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   door_visits = 0;
  int   moving_seen = 0;
  logic door_prev = 1'b0;

  always #5 clk = ~clk;

  lift_scheduler #(.N_FLOORS(4), .TRAVEL_CYCLES(2), .DOOR_CYCLES(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .i_up_req_queue  (up_q),
    .i_dn_req_queue  (dn_q),
    .i_flr_req_queue (flr_q),
    .o_flr_pos       (o_flr_pos),
    .o_up_clr        (o_up_clr),
    .o_dn_clr        (o_dn_clr),
    .o_flr_clr       (o_flr_clr),
    .o_dir_up        (o_dir_up),
    .o_moving        (o_moving),
    .o_door_open     (o_door_open)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock; models request_handler retiring strobed bits one cycle after the strobe.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    up_q  = up_q & ~pend_up;
    dn_q  = dn_q & ~pend_dn;
    flr_q = flr_q & ~pend_flr;
    pend_up = '0; pend_dn = '0; pend_flr = '0;
    if (o_door_open && !door_prev) door_visits++;
    door_prev = o_door_open;
    if (o_moving) moving_seen++;
    if (o_up_clr || o_dn_clr || o_flr_clr) begin
      if (sb.size() == 0) begin
        chk("unexpected_clr", 32'({o_up_clr, o_dn_clr, o_flr_clr}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("clr_pos", 32'(o_flr_pos), 32'(e.pos));
        chk("clr_bits", 32'({o_up_clr, o_dn_clr, o_flr_clr}), 32'(e.bits));
        chk("clr_dir", 32'(o_dir_up), 32'(e.dir));
      end
      pend_up  = o_up_clr  ? o_flr_pos : 4'b0;
      pend_dn  = o_dn_clr  ? o_flr_pos : 4'b0;
      pend_flr = o_flr_clr ? o_flr_pos : 4'b0;
    end
  endtask

  task automatic do_reset();
    up_q = '0; dn_q = '0; flr_q = '0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    door_visits = 0;
    moving_seen = 0;
  endtask

  task automatic push_exp(input logic [3:0] pos, input logic [2:0] bits, input logic dir);
    exp_t e;
    e.pos = pos; e.bits = bits; e.dir = dir;
    sb.push_back(e);
  endtask

  int cnt;
  int budget;

  initial begin
    // Reset state
    do_reset();
    chk("rst_pos", 32'(o_flr_pos), 32'h1);
    chk("rst_dir", 32'(o_dir_up), 32'd1);
    chk("rst_outs", 32'({o_up_clr, o_dn_clr, o_flr_clr, o_moving, o_door_open}), 32'd0);
    step();
    chk("idle_outs", 32'({o_flr_pos, o_moving, o_door_open}), 32'({4'b0001, 2'b00}));

    // Car call to floor 2: pass floor 1, stop at 2, direction flips at the empty top end
    flr_q = 4'b0100;
    push_exp(4'b0100, 3'b001, 1'b0);
    step();
    chk("a_moving", 32'(o_moving), 32'd1);
    step(); step();
    chk("a_pos1", 32'(o_flr_pos), 32'h2);
    chk("a_arrive", 32'({o_moving, o_door_open}), 32'd0);
    step();
    chk("a_resume", 32'(o_moving), 32'd1);
    step(); step();
    chk("a_pos2", 32'(o_flr_pos), 32'h4);
    step();
    chk("a_door", 32'(o_door_open), 32'd1);
    cnt = 0; budget = 0;
    while (o_door_open && budget < 10) begin cnt++; budget++; step(); end
    chk("a_door_len", 32'(cnt), 32'd3);
    chk("a_end_dir", 32'(o_dir_up), 32'd0);
    chk("a_sb_empty", 32'(sb.size()), 32'd0);

    // Hall up at 1 and hall down at 2
    do_reset();
    up_q = 4'b0010; dn_q = 4'b0100;
    push_exp(4'b0010, 3'b100, 1'b1);
    push_exp(4'b0100, 3'b010, 1'b0);
    for (int i = 0; i < 30; i++) step();
    chk("b_visits", 32'(door_visits), 32'd2);
    chk("b_pos", 32'(o_flr_pos), 32'h4);
    chk("b_dir", 32'(o_dir_up), 32'd0);
    chk("b_queues", 32'({up_q, dn_q}), 32'd0);
    chk("b_sb_empty", 32'(sb.size()), 32'd0);

    // Car call at the current floor: door next cycle, no movement
    do_reset();
    flr_q = 4'b0001;
    push_exp(4'b0001, 3'b001, 1'b0);
    step();
    chk("c_door", 32'(o_door_open), 32'd1);
    for (int i = 0; i < 6; i++) step();
    chk("c_no_move", 32'(moving_seen), 32'd0);
    chk("c_pos", 32'(o_flr_pos), 32'h1);
    chk("c_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-move between floors 1 and 2
    do_reset();
    flr_q = 4'b1000;
    step(); step(); step(); step();
    chk("d_moving", 32'({o_flr_pos, o_moving}), 32'({4'b0010, 1'b1}));
    reset = 1'b0;
    flr_q = '0;
    step();
    chk("d_rst_pos", 32'(o_flr_pos), 32'h1);
    chk("d_rst_outs", 32'({o_dir_up, o_up_clr, o_dn_clr, o_flr_clr, o_moving, o_door_open}), 32'h20);
    reset = 1'b1;
    step(); step();
    chk("d_idle", 32'({o_moving, o_door_open}), 32'd0);

    // New car call at the open floor during door cycle 2
    do_reset();
    flr_q = 4'b0100;
    push_exp(4'b0100, 3'b001, 1'b0);
    budget = 0;
    while (!o_door_open && budget < 20) begin budget++; step(); end
    chk("e_door_reached", 32'(o_door_open), 32'd1);
    step();
    flr_q = flr_q | 4'b0100;
    push_exp(4'b0100, 3'b001, 1'b1);
    step();
    cnt = 0; budget = 0;
    while (o_door_open && budget < 10) begin cnt++; budget++; step(); end
`ifdef LIFT_DOOR_REOPEN_EN
    chk("e_door_extra", 32'(cnt), 32'd3);
    step();
    chk("e_stays_closed", 32'(o_door_open), 32'd0);
`else
    chk("e_door_extra", 32'(cnt), 32'd1);
    step();
    chk("e_reopen", 32'(o_door_open), 32'd1);
`endif
    for (int i = 0; i < 5; i++) step();
    chk("e_flr_q", 32'(flr_q), 32'd0);
    chk("e_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule
